set_job_scheduler: RTL and testbench
====================================

// Module: set_job_scheduler
// PURPOSE
//   Shares one SET circle-set engine between two requesters (e.g. host + self-test).
//   Round-robin arbitration accepts one job (central, radius, mode) at a time and drives the SET en handshake.
//   It waits for the SET valid pulse and routes candidate back to the owning requester.
//   A watchdog aborts jobs when SET never answers.
// PARAMETERS
//   TIMEOUT  1023  max cycles in WAIT before abort (>=1)
//   TO_W     10    width of watchdog counter (2**TO_W > TIMEOUT)
// PORTS
//   clk            in   1   system clock, rising edge
//   rst            in   1   synchronous, active-low reset (rst==0 resets on clk edge)
//   req_valid      in   2   per-requester job request, level, held until accepted
//   req_central    in   48  {req1,req0}; each 24b {x1,y1,x2,y2,x3,y3}, 4b each
//   req_radius     in   24  {req1,req0}; each 12b {r1,r2,r3}
//   req_mode       in   4   {req1,req0}; 00 A, 01 A|B, 10 A-B, 11 A&B
//   req_ready      out  2   one-hot accept pulse, 1 cycle
//   rsp_valid      out  1   result pulse, 1 cycle
//   rsp_id         out  1   requester owning the result
//   rsp_candidate  out  8   candidate count from SET (0 on error)
//   rsp_err        out  1   1 = watchdog abort
//   set_en         out  1   SET start, exactly 1 cycle
//   set_central    out  24  to SET, stable from set_en through set_valid
//   set_radius     out  12  to SET, same stability rule
//   set_mode       out  2   to SET, same stability rule
//   set_busy       in   1   SET busy; no issue while high
//   set_valid      in   1   SET result strobe
//   set_candidate  in   8   SET result, sampled when set_valid==1
// BEHAVIOUR
//   Reset: state=IDLE, rr_ptr=0 (req0 preferred), all outputs 0, watchdog=0.
//   FSM IDLE->ISSUE->WAIT->RESP->IDLE.
//   IDLE:
//     - If set_busy==0 and any req_valid, grant one requester.
//     - Both requesting: grant the one != last granted. After reset, req0 wins.
//     - Grant cycle: req_ready[g]=1; latch the job and g; rr_ptr updates; go to ISSUE.
//     - If set_busy==1, or no request: no grant, req_ready=0, stay in IDLE.
//   ISSUE:
//     - set_en=1 for this cycle only.
//     - set_central/set_radius/set_mode drive the latched job.
//     - Go to WAIT; watchdog=0.
//   WAIT:
//     - If set_valid: latch set_candidate, err=0, go to RESP.
//     - Else watchdog+1. When watchdog==TIMEOUT-1 with no set_valid: candidate=0, err=1, go to RESP.
//     - set_valid in the same cycle as expiry: valid wins, err=0.
//   RESP:
//     - rsp_valid=1 for one cycle with rsp_id/rsp_candidate/rsp_err; go to IDLE.
//     - Data outputs hold until the next RESP; only rsp_valid pulses.
//   Latency: SET valid L cycles after set_en gives rsp_valid L+2 cycles after the req_ready pulse.
//   set_valid outside WAIT (stray or late after abort) is ignored; no state change.
//   req_valid dropped before grant is legal; no latch, no error.
//   At most one job is outstanding; no queue. Next grant is no earlier than the cycle after RESP.
//   Reset (rst==0) in any state: back to IDLE next edge; any in-flight job is discarded silently.
//   Watchdog: TO_W bits, saturating compare, no wrap.
// TESTING
//   1 req0 {x1=4,y1=4} r1=3 mode 00; model busy 4 cyc, valid w/ 8'd29
//     -> req_ready=01, set_en 1 cyc, rsp_valid id=0 cand=29 err=0 exactly 6 cyc after accept.
//   2 Both req_valid held high for 4 jobs after reset
//     -> grant order 0,1,0,1; set_mode follows each owner's req_mode (e.g. 01 then 11).
//   3 set_busy=1 for 10 cyc with req_valid=01
//     -> req_ready stays 0 all 10 cyc; grant on the first cycle busy==0.
//   4 Model never asserts valid, TIMEOUT=16
//     -> rsp_valid with err=1 cand=0 at cycle 16 of WAIT; next job issues normally.
//   5 set_valid on the expiry cycle
//     -> err=0, cand=model value; late set_valid after an abort -> no rsp_valid.
//   6 rst=0 one cycle while in WAIT
//     -> all outputs 0 next cycle; following set_valid ignored; next grant goes to req0.

Source files
------------

// File: rtl/set_job_scheduler.sv
// Round-robin scheduler sharing one SET circle-set engine between two requesters,
// with a watchdog that aborts jobs the engine never answers.
module set_job_scheduler #(
  parameter int TIMEOUT = 1023,
  parameter int TO_W    = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  input  logic [47:0] req_central,
  input  logic [23:0] req_radius,
  input  logic [3:0]  req_mode,
  output logic [1:0]  req_ready,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [7:0]  rsp_candidate,
  output logic        rsp_err,
  output logic        set_en,
  output logic [23:0] set_central,
  output logic [11:0] set_radius,
  output logic [1:0]  set_mode,
  input  logic        set_busy,
  input  logic        set_valid,
  input  logic [7:0]  set_candidate
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT - 1);

  state_t          state_r;
  state_t          state_s;
  logic            rr_ptr_r;
  logic            owner_r;
  logic [TO_W-1:0] wd_r;
  logic            grant_s;
  logic            gnt_id_s;
  logic [1:0]      ready_s;
  logic            wd_exp_s;

  // Next-state decode and round-robin grant selection
  always_comb begin
    state_s  = state_r;
    grant_s  = 1'b0;
    gnt_id_s = rr_ptr_r;
    ready_s  = 2'b00;
    wd_exp_s = (wd_r >= WD_LAST);
    case (state_r)
      IDLE: begin
        if (!set_busy && (req_valid != 2'b00)) begin
          grant_s = 1'b1;
          if (req_valid == 2'b11) begin
            gnt_id_s = rr_ptr_r;
          end else begin
            gnt_id_s = req_valid[1];
          end
          ready_s = gnt_id_s ? 2'b10 : 2'b01;
          state_s = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: state_s = WAIT;
      WAIT: begin
        if (set_valid || wd_exp_s) begin
          state_s = RESP;
        end else begin
          state_s = WAIT;
        end
      end
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // The accept pulse must be seen in the grant cycle itself; it is masked during reset
  assign req_ready = (rst && grant_s) ? ready_s : 2'b00;

  // State, job latch, watchdog and response registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r       <= IDLE;
      rr_ptr_r      <= 1'b0;
      owner_r       <= 1'b0;
      wd_r          <= '0;
      set_en        <= 1'b0;
      set_central   <= 24'd0;
      set_radius    <= 12'd0;
      set_mode      <= 2'b00;
      rsp_valid     <= 1'b0;
      rsp_id        <= 1'b0;
      rsp_candidate <= 8'd0;
      rsp_err       <= 1'b0;
    end else begin
      state_r   <= state_s;
      set_en    <= 1'b0;
      rsp_valid <= 1'b0;
      case (state_r)
        IDLE: begin
          if (grant_s) begin
            owner_r     <= gnt_id_s;
            rr_ptr_r    <= ~gnt_id_s;
            set_en      <= 1'b1;
            set_central <= gnt_id_s ? req_central[47:24] : req_central[23:0];
            set_radius  <= gnt_id_s ? req_radius[23:12]  : req_radius[11:0];
            set_mode    <= gnt_id_s ? req_mode[3:2]      : req_mode[1:0];
          end
        end
        ISSUE: wd_r <= '0;
        WAIT: begin
          // A result arriving on the expiry cycle still counts as a good result
          if (set_valid) begin
            rsp_valid     <= 1'b1;
            rsp_id        <= owner_r;
            rsp_candidate <= set_candidate;
            rsp_err       <= 1'b0;
          end else if (wd_exp_s) begin
            rsp_valid     <= 1'b1;
            rsp_id        <= owner_r;
            rsp_candidate <= 8'd0;
            rsp_err       <= 1'b1;
          end else begin
            wd_r <= wd_r + TO_W'(1);
          end
        end
        RESP:    wd_r <= wd_r;
        default: wd_r <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_set_job_scheduler.sv
// Directed bench for set_job_scheduler: a per-cycle vector table for alternating
// grants, plus hand sequences for latency, busy stall, timeout, and reset abort.
module tb_set_job_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [47:0] req_central;
  logic [23:0] req_radius;
  logic [3:0]  req_mode;
  logic [1:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_id;
  logic [7:0]  rsp_candidate;
  logic        rsp_err;
  logic        set_en;
  logic [23:0] set_central;
  logic [11:0] set_radius;
  logic [1:0]  set_mode;
  logic        set_busy;
  logic        set_valid;
  logic [7:0]  set_candidate;

  int checks = 0;
  int errors = 0;

  set_job_scheduler #(.TIMEOUT(16), .TO_W(5)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_central(req_central), .req_radius(req_radius),
    .req_mode(req_mode), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_candidate(rsp_candidate),
    .rsp_err(rsp_err),
    .set_en(set_en), .set_central(set_central), .set_radius(set_radius),
    .set_mode(set_mode), .set_busy(set_busy), .set_valid(set_valid),
    .set_candidate(set_candidate)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1);
  end

  typedef struct {
    logic [1:0] rv;
    logic       sv;
    logic [7:0] cand;
    logic [1:0] e_ready;
    logic       e_en;
    logic       e_rspv;
    logic       e_id;
    logic [7:0] e_cand;
    logic [1:0] e_mode;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(input logic [1:0] rv, input logic sv, input logic [7:0] cand,
                              input logic [1:0] e_ready, input logic e_en, input logic e_rspv,
                              input logic e_id, input logic [7:0] e_cand, input logic [1:0] e_mode);
    vec_t v;
    v.rv = rv; v.sv = sv; v.cand = cand; v.e_ready = e_ready; v.e_en = e_en;
    v.e_rspv = e_rspv; v.e_id = e_id; v.e_cand = e_cand; v.e_mode = e_mode;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, then let outputs settle
  task automatic cyc(input logic [1:0] rv, input logic busy, input logic sv, input logic [7:0] cand);
    @(negedge clk);
    req_valid = rv; set_busy = busy; set_valid = sv; set_candidate = cand;
    #1;
  endtask

  // Called right after the grant cycle; SET answers lat cycles after set_en
  task automatic finish_job(input int lat, input logic [7:0] cand, input logic id, input string nm);
    cyc(2'b00, 1'b0, 1'b0, 8'd0);
    chk({nm, " set_en"}, 32'(set_en), 32'd1);
    for (int k = 1; k < lat; k++) begin
      cyc(2'b00, 1'b0, 1'b0, 8'd0);
      chk({nm, " wait_quiet"}, {30'd0, set_en, rsp_valid}, 32'd0);
    end
    cyc(2'b00, 1'b0, 1'b1, cand);
    chk({nm, " no_early_rsp"}, 32'(rsp_valid), 32'd0);
    cyc(2'b00, 1'b0, 1'b0, 8'd0);
    chk({nm, " rsp"}, {22'd0, rsp_valid, rsp_id, rsp_candidate, rsp_err}, {22'd0, 1'b1, id, cand, 1'b0});
  endtask

  initial begin
    rst = 1'b0; req_valid = 2'b00; set_busy = 1'b0; set_valid = 1'b0; set_candidate = 8'd0;
    req_central = {24'hABCDEF, 24'h440000};
    req_radius  = {12'h123, 12'h300};
    req_mode    = {2'b11, 2'b01};

    tbl[0]  = mk(2'b11, 1'b0, 8'd0,  2'b01, 1'b0, 1'b0, 1'b0, 8'd0,  2'b00);
    tbl[1]  = mk(2'b11, 1'b0, 8'd0,  2'b00, 1'b1, 1'b0, 1'b0, 8'd0,  2'b01);
    tbl[2]  = mk(2'b11, 1'b1, 8'd10, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0,  2'b01);
    tbl[3]  = mk(2'b11, 1'b0, 8'd0,  2'b00, 1'b0, 1'b1, 1'b0, 8'd10, 2'b01);
    tbl[4]  = mk(2'b11, 1'b0, 8'd0,  2'b10, 1'b0, 1'b0, 1'b0, 8'd10, 2'b01);
    tbl[5]  = mk(2'b11, 1'b0, 8'd0,  2'b00, 1'b1, 1'b0, 1'b0, 8'd10, 2'b11);
    tbl[6]  = mk(2'b11, 1'b1, 8'd20, 2'b00, 1'b0, 1'b0, 1'b0, 8'd10, 2'b11);
    tbl[7]  = mk(2'b11, 1'b0, 8'd0,  2'b00, 1'b0, 1'b1, 1'b1, 8'd20, 2'b11);
    tbl[8]  = mk(2'b11, 1'b0, 8'd0,  2'b01, 1'b0, 1'b0, 1'b1, 8'd20, 2'b11);
    tbl[9]  = mk(2'b11, 1'b0, 8'd0,  2'b00, 1'b1, 1'b0, 1'b1, 8'd20, 2'b01);
    tbl[10] = mk(2'b11, 1'b1, 8'd30, 2'b00, 1'b0, 1'b0, 1'b1, 8'd20, 2'b01);
    tbl[11] = mk(2'b11, 1'b0, 8'd0,  2'b00, 1'b0, 1'b1, 1'b0, 8'd30, 2'b01);
    tbl[12] = mk(2'b11, 1'b0, 8'd0,  2'b10, 1'b0, 1'b0, 1'b0, 8'd30, 2'b01);
    tbl[13] = mk(2'b11, 1'b0, 8'd0,  2'b00, 1'b1, 1'b0, 1'b0, 8'd30, 2'b11);
    tbl[14] = mk(2'b11, 1'b1, 8'd40, 2'b00, 1'b0, 1'b0, 1'b0, 8'd30, 2'b11);
    tbl[15] = mk(2'b11, 1'b0, 8'd0,  2'b00, 1'b0, 1'b1, 1'b1, 8'd40, 2'b11);
    tbl[16] = mk(2'b00, 1'b0, 8'd0,  2'b00, 1'b0, 1'b0, 1'b1, 8'd40, 2'b11);

    // Reset state
    cyc(2'b00, 1'b0, 1'b0, 8'd0);
    cyc(2'b11, 1'b0, 1'b0, 8'd0);
    chk("reset_outputs", {set_en, rsp_valid, rsp_id, rsp_err, rsp_candidate, set_mode, req_ready},
        32'd0);
    chk("reset_set_data", {set_central, set_radius[7:0]}, 32'd0);
    cyc(2'b00, 1'b0, 1'b0, 8'd0);
    rst = 1'b1;

    // Alternating grants with both requesters held high
    for (int i = 0; i < 17; i++) begin
      cyc(tbl[i].rv, 1'b0, tbl[i].sv, tbl[i].cand);
      chk($sformatf("tbl%0d ready", i), 32'(req_ready), 32'(tbl[i].e_ready));
      chk($sformatf("tbl%0d en_rspv", i), {30'd0, set_en, rsp_valid}, {30'd0, tbl[i].e_en, tbl[i].e_rspv});
      chk($sformatf("tbl%0d rsp_data", i), {23'd0, rsp_id, rsp_candidate}, {23'd0, tbl[i].e_id, tbl[i].e_cand});
      chk($sformatf("tbl%0d mode", i), 32'(set_mode), 32'(tbl[i].e_mode));
    end

    // Single job from req0, SET answers 4 cycles after set_en
    req_mode = {2'b11, 2'b00};
    cyc(2'b01, 1'b0, 1'b0, 8'd0);
    chk("t1 ready", 32'(req_ready), 32'd1);
    cyc(2'b00, 1'b0, 1'b0, 8'd0);
    chk("t1 set_job", {set_en, set_central, set_radius[11:8], set_mode},
        {1'b1, 24'h440000, 4'h3, 2'b00} );
    for (int k = 1; k < 4; k++) begin
      cyc(2'b00, 1'b0, 1'b0, 8'd0);
      chk("t1 en_once", {30'd0, set_en, rsp_valid}, 32'd0);
    end
    cyc(2'b00, 1'b0, 1'b1, 8'd29);
    chk("t1 stable_central", 32'(set_central), 32'h440000);
    cyc(2'b00, 1'b0, 1'b0, 8'd0);
    chk("t1 rsp", {rsp_valid, rsp_id, rsp_candidate, rsp_err}, {1'b1, 1'b0, 8'd29, 1'b0});
    cyc(2'b00, 1'b0, 1'b0, 8'd0);
    chk("t1 rsp_pulse_hold", {rsp_valid, rsp_candidate}, {1'b0, 8'd29});

    // Busy stall
    for (int k = 0; k < 10; k++) begin
      cyc(2'b01, 1'b1, 1'b0, 8'd0);
      chk("t3 busy_no_grant", 32'(req_ready), 32'd0);
    end
    cyc(2'b01, 1'b0, 1'b0, 8'd0);
    chk("t3 grant_after_busy", 32'(req_ready), 32'd1);
    finish_job(2, 8'd61, 1'b0, "t3");

    // Watchdog abort, then a normal job from req1
    cyc(2'b01, 1'b0, 1'b0, 8'd0);
    chk("t4 ready", 32'(req_ready), 32'd1);
    cyc(2'b00, 1'b0, 1'b0, 8'd0);
    for (int k = 0; k < 16; k++) begin
      cyc(2'b00, 1'b0, 1'b0, 8'd0);
      chk("t4 no_rsp_before_expiry", 32'(rsp_valid), 32'd0);
    end
    cyc(2'b00, 1'b0, 1'b0, 8'd0);
    chk("t4 abort_rsp", {rsp_valid, rsp_id, rsp_candidate, rsp_err}, {1'b1, 1'b0, 8'd0, 1'b1});
    cyc(2'b10, 1'b0, 1'b0, 8'd0);
    chk("t4 next_grant", 32'(req_ready), 32'd2);
    finish_job(3, 8'd77, 1'b1, "t4b");

    // set_valid on the expiry cycle wins
    cyc(2'b01, 1'b0, 1'b0, 8'd0);
    cyc(2'b00, 1'b0, 1'b0, 8'd0);
    for (int k = 0; k < 15; k++) cyc(2'b00, 1'b0, 1'b0, 8'd0);
    cyc(2'b00, 1'b0, 1'b1, 8'd55);
    chk("t5 expiry_valid_no_rsp_yet", 32'(rsp_valid), 32'd0);
    cyc(2'b00, 1'b0, 1'b0, 8'd0);
    chk("t5 valid_wins", {rsp_valid, rsp_candidate, rsp_err}, {1'b1, 8'd55, 1'b0});

    // Late set_valid after an abort is ignored
    cyc(2'b01, 1'b0, 1'b0, 8'd0);
    cyc(2'b00, 1'b0, 1'b0, 8'd0);
    for (int k = 0; k < 16; k++) cyc(2'b00, 1'b0, 1'b0, 8'd0);
    cyc(2'b00, 1'b0, 1'b0, 8'd0);
    chk("t5 abort", {rsp_valid, rsp_err}, {1'b1, 1'b1});
    cyc(2'b00, 1'b0, 1'b1, 8'd99);
    cyc(2'b00, 1'b0, 1'b0, 8'd0);
    cyc(2'b00, 1'b0, 1'b0, 8'd0);
    chk("t5 late_valid_ignored", {rsp_valid, rsp_candidate, set_en}, {1'b0, 8'd0, 1'b0});

    // Reset while in WAIT discards the job and restores req0 priority
    cyc(2'b01, 1'b0, 1'b0, 8'd0);
    chk("t6 ready", 32'(req_ready), 32'd1);
    cyc(2'b00, 1'b0, 1'b0, 8'd0);
    cyc(2'b00, 1'b0, 1'b0, 8'd0);
    @(negedge clk); rst = 1'b0; #1;
    chk("t6 ready_masked", 32'(req_ready), 32'd0);
    @(negedge clk); rst = 1'b1; set_valid = 1'b1; set_candidate = 8'd88; #1;
    chk("t6 outputs_zero", {set_en, rsp_valid, rsp_id, rsp_err, rsp_candidate, set_mode, req_ready},
        32'd0);
    chk("t6 set_data_zero", {set_central, set_radius[7:0]}, 32'd0);
    cyc(2'b00, 1'b0, 1'b0, 8'd0);
    chk("t6 valid_ignored", {rsp_valid, rsp_candidate}, 32'd0);
    cyc(2'b11, 1'b0, 1'b0, 8'd0);
    chk("t6 req0_wins", 32'(req_ready), 32'd1);
    finish_job(1, 8'd12, 1'b0, "t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
